// File: rtl/param_mux_scanner_pkg.sv
// Shared constants and helpers for the channel scanner and the lab top-levels that use it.
package param_mux_pkg;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam int DEF_N_CH  = 7;
    localparam int DEF_DIV_W = 8;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } scan_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/param_mux_scanner_if.sv
// Control/data bundle between a lab top-level (master) and the scanner (slave).
interface param_mux_scanner_if
    import param_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int DIV_W = DEF_DIV_W,
    parameter int SEL_W = sel_width(N_CH)
) ();
    logic             Enable;
    logic             Mode;
    logic [SEL_W-1:0] MuxSelect;
    logic [N_CH-1:0]  Input;
    logic [DIV_W-1:0] Rate;
    logic             Out;
    logic [SEL_W-1:0] CurSel;
    logic             Tick;
    logic [N_CH-1:0]  Frame;
    logic             FrameValid;

    modport master (
        output Enable, Mode, MuxSelect, Input, Rate,
        input  Out, CurSel, Tick, Frame, FrameValid
    );

    modport slave (
        input  Enable, Mode, MuxSelect, Input, Rate,
        output Out, CurSel, Tick, Frame, FrameValid
    );
endinterface

// File: rtl/param_mux_scanner_rate_prescaler.sv
// Enabled-cycle prescaler: Step is high on the cycle the count has reached Rate.
module rate_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic             Clear,
    input  logic [DIV_W-1:0] Rate,
    output logic             Step
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // >= so a Rate lowered below the running count fires immediately
    assign Step = Enable && !Clear && (cnt_q >= Rate);

    always_comb begin
        cnt_d = cnt_q;
        if (Enable) begin
            if (Clear || Step) cnt_d = '0;
            else               cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/param_mux_scanner.sv
// N-channel 1-bit selector: registered manual mux, or auto scan that serialises
// channels on Out and assembles each full pass into Frame.
module param_mux_scanner
    import param_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = sel_width(N_CH),
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic          Clock,
    input  logic          Resetn,
    param_mux_scanner_if.slave bus
);
    localparam int               EXT_W   = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    scan_state_e      state_q, state_d;
    logic             out_q, out_d;
    logic [SEL_W-1:0] cursel_q, cursel_d;
    logic [N_CH-1:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]  frame_q, frame_d;
    logic             tick_q, tick_d;
    logic             fv_q, fv_d;

    logic             auto_run;
    logic             step;
    logic [EXT_W-1:0] in_ext;

    // Zero-padded so out-of-range manual selects read 0
    assign in_ext   = EXT_W'(bus.Input);
    assign auto_run = (bus.Mode == MODE_AUTO) && (state_q == S_AUTO);

    rate_prescaler #(.DIV_W(DIV_W)) u_presc (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Enable (bus.Enable),
        .Clear  (!auto_run),
        .Rate   (bus.Rate),
        .Step   (step)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        cursel_d = cursel_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        tick_d   = 1'b0;
        fv_d     = 1'b0;
        if (bus.Enable) begin
            state_d = (bus.Mode == MODE_AUTO) ? S_AUTO : S_MANUAL;
            if (bus.Mode == MODE_MANUAL) begin
                cursel_d = bus.MuxSelect;
                out_d    = in_ext[bus.MuxSelect];
                shadow_d = '0;
            end else if (state_q == S_MANUAL) begin
                cursel_d = '0;
                shadow_d = '0;
            end else if (step) begin
                out_d  = in_ext[cursel_q];
                tick_d = 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    if (cursel_q == SEL_W'(i)) shadow_d[i] = bus.Input[i];
                end
                if (cursel_q == LAST_CH) begin
                    // last channel is taken live; it never lands in shadow
                    cursel_d = '0;
                    frame_d  = {bus.Input[N_CH-1], shadow_q[N_CH-2:0]};
                    fv_d     = 1'b1;
                    shadow_d = '0;
                end else begin
                    cursel_d = cursel_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_MANUAL;
            out_q    <= 1'b0;
            cursel_q <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            tick_q   <= 1'b0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            cursel_q <= cursel_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            tick_q   <= tick_d;
            fv_q     <= fv_d;
        end
    end

    assign bus.Out        = out_q;
    assign bus.CurSel     = cursel_q;
    assign bus.Tick       = tick_q;
    assign bus.Frame      = frame_q;
    assign bus.FrameValid = fv_q;
endmodule

// File: tb/tb_param_mux_scanner.sv
// Bench for param_mux_scanner with N_CH=7: manual-mode vector table plus
// scoreboarded auto-scan sequences (rate, enable hold, rate cut, reset mid-scan).
module tb_param_mux_scanner;
    localparam int N_CH  = 7;
    localparam int DIV_W = 8;

    logic Clock = 1'b0;
    logic Resetn;
    always #5 Clock = ~Clock;

    param_mux_scanner_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

    param_mux_scanner #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic       out;
        logic [2:0] cursel;
    } sb_t;

    typedef struct {
        logic [2:0] sel;
        logic [6:0] din;
        logic       exp_out;
    } mvec_t;

    sb_t        exp_q[$];
    logic [6:0] frm_q[$];
    int         nvec = 0;
    int         nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One edge, then pop the scoreboard on any strobe the DUT produced
    task automatic clk_mon();
        sb_t e;
        @(posedge Clock);
        #1;
        if (bus.Tick) begin
            if (exp_q.size() == 0) chk("sb_extra_tick", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sb_out", bus.Out, e.out);
                chk("sb_cursel", bus.CurSel, e.cursel);
            end
        end
        if (bus.FrameValid) begin
            if (frm_q.size() == 0) chk("sb_extra_frame", 1, 0);
            else chk("sb_frame", bus.Frame, frm_q.pop_front());
        end
    endtask

    task automatic push_scan(input logic [6:0] din, input int first, input int n);
        sb_t e;
        for (int i = first; i < first + n; i++) begin
            e.out    = din[i % N_CH];
            e.cursel = 3'((i + 1) % N_CH);
            exp_q.push_back(e);
        end
    endtask

    // One manual edge to leave auto cleanly, then request auto entry
    task automatic restart_auto(input logic [7:0] r, input logic [6:0] din);
        bus.Mode = 1'b0;
        clk_mon();
        bus.Rate  = r;
        bus.Input = din;
        bus.Mode  = 1'b1;
    endtask

    mvec_t      mv[11];
    logic [6:0] din_b, din_c, din_d, din_e;

    initial begin
        mv[0]  = '{3'd1, 7'b1010010, 1'b1};
        mv[1]  = '{3'd4, 7'b1010010, 1'b1};
        mv[2]  = '{3'd7, 7'b1010010, 1'b0};
        mv[3]  = '{3'd0, 7'b1010010, 1'b0};
        mv[4]  = '{3'd6, 7'b1010010, 1'b1};
        mv[5]  = '{3'd5, 7'b1010010, 1'b0};
        mv[6]  = '{3'd0, 7'b0101101, 1'b1};
        mv[7]  = '{3'd2, 7'b0101101, 1'b1};
        mv[8]  = '{3'd6, 7'b0101101, 1'b0};
        mv[9]  = '{3'd7, 7'b0101101, 1'b0};
        mv[10] = '{3'd3, 7'b0101101, 1'b1};

        Resetn = 1'b0;
        bus.Enable = 1'b1; bus.Mode = 1'b0; bus.MuxSelect = '0;
        bus.Input = 7'h7f; bus.Rate = '0;
        clk_mon();
        chk("rst_out", bus.Out, 0);
        chk("rst_cursel", bus.CurSel, 0);
        chk("rst_tick", bus.Tick, 0);
        chk("rst_frame", bus.Frame, 0);
        chk("rst_fv", bus.FrameValid, 0);
        Resetn = 1'b1;

        // Manual mux table
        for (int i = 0; i < 11; i++) begin
            bus.MuxSelect = mv[i].sel;
            bus.Input     = mv[i].din;
            clk_mon();
            chk("man_out", bus.Out, mv[i].exp_out);
            chk("man_cursel", bus.CurSel, mv[i].sel);
            chk("man_tick", bus.Tick, 0);
        end
        bus.Enable = 1'b0; bus.MuxSelect = 3'd0; bus.Input = 7'b0;
        clk_mon();
        chk("man_hold_out", bus.Out, 1);
        chk("man_hold_cursel", bus.CurSel, 3);
        bus.Enable = 1'b1;

        // A: Rate=0, steps on edges 2..8, one frame
        restart_auto(8'd0, 7'b0110101);
        push_scan(7'b0110101, 0, 7);
        frm_q.push_back(7'b0110101);
        for (int e = 1; e <= 8; e++) begin
            clk_mon();
            chk("A_tick", bus.Tick, e >= 2);
            chk("A_fv", bus.FrameValid, e == 8);
        end
        chk("A_cursel_wrap", bus.CurSel, 0);
        chk("A_sb_empty", exp_q.size() + frm_q.size(), 0);

        // B: Rate=3, Input glitched between steps, two frames
        din_b = 7'b1001011;
        restart_auto(8'd3, din_b);
        push_scan(din_b, 0, 14);
        frm_q.push_back(din_b);
        frm_q.push_back(din_b);
        for (int e = 1; e <= 57; e++) begin
            clk_mon();
            chk("B_tick", bus.Tick, (e >= 5) && ((e - 5) % 4 == 0));
            chk("B_fv", bus.FrameValid, (e == 29) || (e == 57));
            if (e > 5 && (e - 5) % 4 == 1) bus.Input = ~din_b;
            if (e > 5 && (e - 5) % 4 == 3) bus.Input = din_b;
        end
        chk("B_sb_empty", exp_q.size() + frm_q.size(), 0);

        // C: Enable low for 5 edges at CurSel=3, prescaler=2
        din_c = 7'b0011010;
        restart_auto(8'd3, din_c);
        push_scan(din_c, 0, 4);
        for (int e = 1; e <= 22; e++) begin
            bus.Enable = !(e >= 16 && e <= 20);
            clk_mon();
            chk("C_tick", bus.Tick, (e == 5) || (e == 9) || (e == 13) || (e == 22));
            if (e >= 15 && e <= 21) begin
                chk("C_hold_cursel", bus.CurSel, 3);
                chk("C_hold_out", bus.Out, din_c[2]);
                chk("C_hold_frame", bus.Frame, din_b);
                chk("C_hold_fv", bus.FrameValid, 0);
            end
        end
        chk("C_sb_empty", exp_q.size(), 0);

        // D: Rate 10 -> 2 with prescaler at 6
        din_d = 7'b0000101;
        restart_auto(8'd10, din_d);
        push_scan(din_d, 0, 3);
        for (int e = 1; e <= 15; e++) begin
            if (e == 8) bus.Rate = 8'd2;
            clk_mon();
            chk("D_tick", bus.Tick, (e == 8) || (e == 11) || (e == 14));
        end
        chk("D_sb_empty", exp_q.size(), 0);

        // E: reset mid-scan at CurSel=4 with Frame=0x55
        din_e = 7'h55;
        restart_auto(8'd0, din_e);
        push_scan(din_e, 0, 11);
        frm_q.push_back(din_e);
        for (int e = 1; e <= 12; e++) begin
            clk_mon();
            chk("E_tick", bus.Tick, e >= 2);
            if (e == 10) begin
                Resetn = 1'b0;
                #2;
                Resetn = 1'b1;
            end
        end
        chk("E_pre_cursel", bus.CurSel, 4);
        chk("E_pre_frame", bus.Frame, 7'h55);
        Resetn = 1'b0;
        clk_mon();
        Resetn = 1'b1;
        chk("E_rst_out", bus.Out, 0);
        chk("E_rst_cursel", bus.CurSel, 0);
        chk("E_rst_tick", bus.Tick, 0);
        chk("E_rst_frame", bus.Frame, 0);
        chk("E_rst_fv", bus.FrameValid, 0);
        push_scan(din_e, 0, 1);
        clk_mon();
        chk("E_entry_tick", bus.Tick, 0);
        chk("E_entry_cursel", bus.CurSel, 0);
        clk_mon();
        chk("E_first_tick", bus.Tick, 1);
        chk("E_first_frame", bus.Frame, 0);
        chk("E_sb_empty", exp_q.size() + frm_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/param_mux_scanner.md
Name: param_mux_scanner

Overview:
- Parametrised N-channel 1-bit input selector with a registered output.
- Manual mode: acts as a registered N:1 mux driven by MuxSelect.
- Auto mode: steps through all channels at a programmable rate, presents each bit serially on Out, and assembles one full scan into a parallel Frame word with a valid strobe.
- Sits between board switches/sensors and display or serial logic in lab top-levels.

Parameters:
- N_CH, 7, number of input channels (2..64).
- SEL_W, $clog2(N_CH), width of select and channel index.
- DIV_W, 8, width of the rate prescaler.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  synchronous, active-low reset.
- Enable  input  1  when 0, all state holds and strobes are 0.
- Mode  input  1  0 = manual, 1 = auto scan.
- MuxSelect  input  SEL_W  channel index used in manual mode.
- Input  input  N_CH  channel data; bit i is channel i.
- Rate  input  DIV_W  auto mode: one step every Rate+1 enabled cycles.
- Out  output  1  registered selected bit.
- CurSel  output  SEL_W  channel currently or last selected.
- Tick  output  1  1-cycle pulse in the cycle after each auto step.
- Frame  output  N_CH  last complete auto scan; bit i = sample of channel i.
- FrameValid  output  1  1-cycle pulse when Frame updates.

Behaviour:
- Reset: Resetn=0 at a rising Clock edge clears Out, CurSel, prescaler, ModeQ, shadow register, Frame, Tick and FrameValid to 0. Resetn low between edges has no effect. Reset overrides every other input.
- Enable=0: all registers hold; Tick=0 and FrameValid=0.
- Manual mode (Mode=0, Enable=1), one-cycle latency:
  - CurSel <= MuxSelect.
  - Out <= Input[MuxSelect] if MuxSelect < N_CH, else 0.
  - Prescaler and shadow are cleared; Frame holds; strobes are 0.
- Entering auto (Mode=1 and ModeQ=0, Enable=1):
  - CurSel, prescaler and shadow are cleared.
  - No step in this cycle; Out holds.
  - ModeQ tracks Mode on every enabled cycle.
- Auto mode (Mode=1, ModeQ=1, Enable=1):
  - Prescaler increments each cycle.
  - A step occurs when prescaler >= Rate. Using >= means a Rate lowered mid-count fires on the next cycle.
  - On a step:
    - prescaler <= 0.
    - Out <= Input[CurSel].
    - shadow[CurSel] <= Input[CurSel].
    - Tick <= 1.
    - CurSel <= 0 if CurSel == N_CH-1, else CurSel+1.
  - On a step with CurSel == N_CH-1, also:
    - Frame <= shadow with bit N_CH-1 replaced by Input[N_CH-1].
    - FrameValid <= 1.
    - shadow <= 0.
  - Non-step cycles: Tick=0, FrameValid=0, Out holds.
- Rate=0: one step every enabled cycle; a full frame every N_CH cycles.
- First step after entering auto occurs Rate+1 enabled cycles after the entry cycle.
- Auto to manual mid-scan: the partial shadow is discarded and Frame keeps the last complete scan.
- Sampling: Input is sampled only at step edges; changes between steps are ignored.
- CurSel never leaves 0..N_CH-1 in auto mode. Out-of-range values appear only in manual mode and select 0.

Decomposition:
- Shared package param_mux_pkg:
  - MODE_MANUAL = 1'b0 and MODE_AUTO = 1'b1.
  - sel_width(n) function.
  - Default N_CH and DIV_W constants for lab top-levels.
- Sub-module rate_prescaler (DIV_W param):
  - Inputs: Clock, Resetn, Enable, Clear, Rate.
  - Output: Step.
  - Reused by later timer/display blocks.
- The scanner core stays in param_mux_scanner.

Test Plan:
- Manual select, N_CH=7, Input=7'b1010010:
  - MuxSelect=1 -> Out=1 and CurSel=1 one edge later.
  - MuxSelect=4 -> Out=1.
  - MuxSelect=7 -> Out=0.
- Auto scan, Rate=0, Input=7'b0110101 held, Mode raised at cycle 0:
  - Steps on cycles 2..8 give Out = 1,0,1,0,1,1,0.
  - FrameValid pulses once with Frame=7'b0110101.
  - CurSel returns to 0.
- Rate=3:
  - Tick pulses exactly every 4 cycles.
  - FrameValid every 28 cycles.
  - Changing Input between steps does not affect the captured sample.
- Enable dropped for 5 cycles at CurSel=3, prescaler=2:
  - All outputs hold, no pulses.
  - On resume, the next step occurs after 2 more cycles at CurSel=3.
- Rate cut from 10 to 2 while prescaler=6 -> step on the next enabled cycle; later steps every 3 cycles.
- Resetn low for 1 edge mid-scan at CurSel=4 with Frame=7'h55:
  - All outputs become 0.
  - ModeQ clears, so the first cycle after release (Mode still 1) is treated as auto entry.
  - Scan restarts at channel 0.
